// File: rtl/fml_wb_bridge_pkg.sv
// fml_wb_bridge_pkg: shared FSM state type and FML burst geometry for the Wishbone-to-FML bridge
package fml_wb_bridge_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WDATA, RDATA, ACK} state_t;
  localparam int FML_BURST_LEN = 4;
  localparam int FML_LINE_BYTES = 16;
  localparam int FML_LINE_LSB = $clog2(FML_LINE_BYTES);
endpackage

// File: rtl/fml_wb_linebuf.sv
// fml_wb_linebuf: 4x32 line buffer with beat write, byte-masked word update and word read mux;
// FML_WB_BRIDGE_CACHE_EN adds a one-line tag/valid so reads of the held line can skip FML.
module fml_wb_linebuf
  import fml_wb_bridge_pkg::*;
#(
  parameter int TW = 21
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          wr_en,
  input  logic [1:0]    wr_idx,
  input  logic [31:0]   wr_dat,
  input  logic          fill_done,
  input  logic          upd_en,
  input  logic [1:0]    upd_idx,
  input  logic [3:0]    upd_sel,
  input  logic [31:0]   upd_dat,
  input  logic [TW-1:0] line,
  input  logic [1:0]    rd_idx,
  output logic [31:0]   rd_dat,
  output logic          hit
);
  logic [31:0] mem [FML_BURST_LEN];
  always_ff @(posedge sys_clk)
    if (wr_en) mem[wr_idx] <= wr_dat;
    else if (upd_en && hit)
      for (int b = 0; b < 4; b++)
        if (upd_sel[b]) mem[upd_idx][8*b +: 8] <= upd_dat[8*b +: 8];
  assign rd_dat = mem[rd_idx];
`ifdef FML_WB_BRIDGE_CACHE_EN
  logic [TW-1:0] tag;
  logic          valid;
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
    end else if (fill_done) begin
      valid <= 1'b1;
      tag   <= line;
    end
  assign hit = valid && tag == line;
`else
  logic unused_tag;
  assign unused_tag = ^{fill_done, line, sys_rst_n};
  assign hit = 1'b0;
`endif
endmodule

// File: rtl/fml_wb_bridge.sv
// fml_wb_bridge: Wishbone classic slave turning each access into one 4-beat FML burst;
// FML_WB_BRIDGE_CACHE_EN enables a one-line read cache in the line buffer.
module fml_wb_bridge
  import fml_wb_bridge_pkg::*;
#(
  parameter int sdram_depth = 25
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [31:0]            wb_adr_i,
  input  logic [31:0]            wb_dat_i,
  output logic [31:0]            wb_dat_o,
  input  logic [3:0]             wb_sel_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic                   wb_we_i,
  output logic                   wb_ack_o,
  output logic [sdram_depth-1:0] fml_adr,
  output logic                   fml_stb,
  output logic                   fml_we,
  input  logic                   fml_eack,
  input  logic                   fml_ack,
  output logic [3:0]             fml_sel,
  output logic [31:0]            fml_do,
  input  logic [31:0]            fml_di
);
  localparam int TW = sdram_depth - FML_LINE_LSB;
  localparam logic [1:0] LAST = 2'(FML_BURST_LEN - 1);
  state_t state, state_nxt;
  logic [1:0]    cnt, word_q;
  logic [TW-1:0] line_q;
  logic [31:0]   dat_q, buf_dat;
  logic [3:0]    sel_q;
  logic          we_q, hit, cap, unused_adr;
  assign unused_adr = ^{wb_adr_i[31:sdram_depth], wb_adr_i[1:0]};
  // a read beat is captured from the first fml_ack onward, whatever fml_ack does later
  assign cap = state == RDATA && (cnt != 2'd0 || fml_ack);
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      line_q <= '0;
      word_q <= 2'd0;
      dat_q  <= 32'h0;
      sel_q  <= 4'h0;
      we_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == WDATA || cap) ? cnt + 2'd1 : 2'd0;
      if (state == IDLE && wb_cyc_i && wb_stb_i) begin
        line_q <= wb_adr_i[sdram_depth-1:FML_LINE_LSB];
        word_q <= wb_adr_i[3:2];
        sel_q  <= wb_sel_i;
        we_q   <= wb_we_i;
        if (wb_we_i) dat_q <= wb_dat_i;
      end
    end
  // a cached read is resolved in REQ against the latched line, with fml_stb held low
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = wb_cyc_i && wb_stb_i ? REQ : IDLE;
      REQ:     state_nxt = hit && !we_q ? ACK : fml_eack ? (we_q ? WDATA : RDATA) : REQ;
      WDATA:   state_nxt = cnt == LAST ? ACK : WDATA;
      RDATA:   state_nxt = cap && cnt == LAST ? ACK : RDATA;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    fml_stb  = state == REQ && !(hit && !we_q);
    fml_sel  = state == WDATA && cnt == word_q ? sel_q : 4'b0000;
    wb_ack_o = state == ACK && wb_cyc_i;
    wb_dat_o = state == ACK && !we_q ? buf_dat : 32'h0;
  end
  assign fml_adr = {line_q, {FML_LINE_LSB{1'b0}}};
  assign fml_we  = we_q;
  assign fml_do  = dat_q;
  fml_wb_linebuf #(.TW(TW)) u_linebuf (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_en     (cap),
    .wr_idx    (cnt),
    .wr_dat    (fml_di),
    .fill_done (cap && cnt == LAST),
    .upd_en    (state == ACK && we_q),
    .upd_idx   (word_q),
    .upd_sel   (sel_q),
    .upd_dat   (dat_q),
    .line      (line_q),
    .rd_idx    (word_q),
    .rd_dat    (buf_dat),
    .hit       (hit)
  );
endmodule

// File: tb/tb_fml_wb_bridge.sv
// tb_fml_wb_bridge: random Wishbone traffic against a word-level memory model, with the bench acting as FML slave.
module tb_fml_wb_bridge;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
  logic [24:0] fml_adr;
  logic        fml_stb, fml_we;
  logic        fml_eack = 1'b0, fml_ack = 1'b0;
  logic [3:0]  fml_sel;
  logic [31:0] fml_do, fml_di = '0;
`ifdef FML_WB_BRIDGE_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  int checks = 0, errors = 0;
  logic [31:0] fmem [1024];
  logic [31:0] ref_mem [1024];
  bit          cvalid = 1'b0;
  logic [20:0] ctag = '0;

  always #5 sys_clk = ~sys_clk;

  fml_wb_bridge dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .fml_adr(fml_adr), .fml_stb(fml_stb), .fml_we(fml_we), .fml_eack(fml_eack),
    .fml_ack(fml_ack), .fml_sel(fml_sel), .fml_do(fml_do), .fml_di(fml_di)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // one Wishbone access; the bench answers as FML slave (eack after w extra cycles, read beat 0 after d)
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input int w, input int d, input int drop_beat, input int rst_beat,
                      output int lat, output logic [31:0] rdat, output int stb_cyc, output int wbeats);
    int phase, k, rw, stray;
    bit done;
    logic [3:0] es;
    phase = 0; k = 0; rw = 0; stray = 0; done = 1'b0;
    lat = 0; rdat = '0; stb_cyc = 0; wbeats = 0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    for (int c = 1; c <= w + d + 12 && !done; c++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      fml_eack = 1'b0; fml_ack = 1'b0; fml_di = $urandom;
      if (!fml_stb && (phase == 0 || phase == 1)) begin
        fml_eack = $urandom_range(0, 3) == 0;
        fml_ack  = $urandom_range(0, 3) == 0;
      end
      if (wb_ack_o) begin
        lat = c; rdat = wb_dat_o; wb_stb_i = 1'b0; done = 1'b1;
      end
      if (phase == 1) begin
        es = (k == int'(adr[3:2])) ? sel : 4'b0000;
        chk("wr_sel", 32'(fml_sel), 32'(es));
        chk("wr_do", fml_do, dat);
        for (int b = 0; b < 4; b++)
          if (fml_sel[b]) fmem[{adr[11:4], 2'(k)}][8*b +: 8] = fml_do[8*b +: 8];
        wbeats++; k++;
        if (k == drop_beat) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
        if (k == 4) phase = 0;
      end else if (fml_sel != 4'b0000) stray++;
      if (phase == 2) begin
        if (rw == 0) begin phase = 3; k = 0; end
        else rw--;
      end
      if (phase == 3) begin
        if (k == rst_beat) begin
          sys_rst_n = 1'b0;
          #1;
          chk("rst_stb", 32'(fml_stb), 32'h0);
          chk("rst_ack", 32'(wb_ack_o), 32'h0);
          chk("rst_adr", 32'(fml_adr), 32'h0);
          wb_cyc_i = 1'b0; wb_stb_i = 1'b0; done = 1'b1;
        end else begin
          fml_ack = k == 0;
          fml_di = fmem[{adr[11:4], 2'(k)}];
          k++;
          if (k == 4) phase = 0;
        end
      end
      if (fml_stb) begin
        stb_cyc++;
        chk("fml_adr", 32'(fml_adr), {7'b0, adr[24:4], 4'b0});
        chk("fml_we", 32'(fml_we), 32'(we));
        if (stb_cyc == w + 1) begin
          fml_eack = 1'b1; phase = we ? 1 : 2; k = 0; rw = d;
        end
      end
    end
    chk("stray_sel", 32'(stray), 32'h0);
    if (lat != 0) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk("ack_1cyc", 32'(wb_ack_o), 32'h0);
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; fml_eack = 1'b0; fml_ack = 1'b0;
    if (!sys_rst_n) begin
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
    end
  endtask

  task automatic do_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int w, input int d);
    int lat, sc, wb, idx;
    logic [31:0] rd;
    bit hit;
    idx = int'(adr[11:2]);
    hit = CACHE && !we && cvalid && ctag == adr[24:4];
    xfer(we, adr, dat, sel, w, d, -1, -1, lat, rd, sc, wb);
    if (we) begin
      ref_mem[idx] = merge(ref_mem[idx], dat, sel);
      chk("wr_lat", 32'(lat), 32'(6 + w));
      chk("wr_beats", 32'(wb), 32'd4);
      chk("wr_stb", 32'(sc), 32'(w + 1));
      chk("wr_mem", fmem[idx], ref_mem[idx]);
    end else begin
      chk("rd_dat", rd, ref_mem[idx]);
      chk("rd_lat", 32'(lat), hit ? 32'd2 : 32'(6 + w + d));
      chk("rd_stb", 32'(sc), hit ? 32'd0 : 32'(w + 1));
      cvalid = 1'b1; ctag = adr[24:4];
    end
  endtask

  initial begin
    int lat, sc, wb;
    logic [31:0] rd, v;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom; fmem[i] = v; ref_mem[i] = v;
    end
    for (int i = 0; i < 4; i++) begin
      fmem[128 + i] = 32'h11 * (i + 1); ref_mem[128 + i] = 32'h11 * (i + 1);
    end
    repeat (3) @(negedge sys_clk);
    chk("reset_ack", 32'(wb_ack_o), 32'h0);
    chk("reset_dat", wb_dat_o, 32'h0);
    chk("reset_stb", 32'(fml_stb), 32'h0);
    chk("reset_we", 32'(fml_we), 32'h0);
    chk("reset_adr", 32'(fml_adr), 32'h0);
    chk("reset_sel", 32'(fml_sel), 32'h0);
    chk("reset_do", fml_do, 32'h0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    do_access(1'b1, 32'h0000_0108, 32'hDEAD_BEEF, 4'b1111, 2, 0);
    do_access(1'b0, 32'h0000_020C, 32'h0, 4'b1111, 1, 4);
    do_access(1'b1, 32'h0000_0300, $urandom, 4'b0010, 0, 0);
    do_access(1'b0, 32'h0000_0300, 32'h0, 4'b1111, 0, 1);
    xfer(1'b0, 32'h0000_0210, 32'h0, 4'b1111, 1, 2, -1, 2, lat, rd, sc, wb);
    cvalid = 1'b0;
    chk("rst_noack", 32'(lat), 32'h0);
    do_access(1'b0, 32'h0000_020C, 32'h0, 4'b1111, 0, 0);
    v = $urandom;
    xfer(1'b1, 32'h0000_0204, v, 4'b1111, 0, 0, 2, -1, lat, rd, sc, wb);
    ref_mem[129] = v;
    chk("drop_noack", 32'(lat), 32'h0);
    chk("drop_beats", 32'(wb), 32'd4);
    do_access(1'b0, 32'h0000_0204, 32'h0, 4'b1111, 0, 0);
    do_access(1'b0, 32'h0000_0200, 32'h0, 4'b1111, 0, 2);
    do_access(1'b0, 32'h0000_0204, 32'h0, 4'b1111, 0, 0);
    do_access(1'b1, 32'h0000_0204, $urandom, 4'b1111, 1, 0);
    do_access(1'b0, 32'h0000_0204, 32'h0, 4'b1111, 0, 0);
    for (int n = 0; n < 40; n++)
      do_access(1'($urandom_range(0, 1)), 32'h200 + 32'($urandom_range(0, 15)) * 4, $urandom,
                4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
